idex_pipe_stage: RTL
====================

// Module: idex_pipe_stage
// PURPOSE
//  Parametrised ID->EX pipeline stage register with valid tracking, stall (hold) and flush (bubble insert).
//  Sits between decode/register-read and execute; carries instruction, NUM_OPS operands, immediate, ALU ctrl, mem/wb ctrl.
//  Optional saturating stall/flush/bubble event counters for pipeline performance analysis.
// PARAMETERS
//  DATA_W      32  width of instruction, operands, immediate
//  NUM_OPS     2   number of register-operand channels carried (>=1)
//  REG_ADDR_W  5   destination register index width
//  ALU_CTRL_W  4   ALU control field width
//  CNT_W       16  perf counter width (used only with IDEX_PERF_CNT_EN)
// PORTS
//  clk            in   1                 clock, all state updates on posedge
//  rst_n          in   1                 reset, asynchronous, active-low
//  stall_i        in   1                 hold EX-side contents this cycle
//  flush_i        in   1                 replace EX-side contents with bubble
//  id_valid_i     in   1                 ID-side slot holds a real instruction
//  id_instr_i     in   DATA_W            instruction word
//  id_ops_i       in   NUM_OPS*DATA_W    operand channels, op k at [k*DATA_W +: DATA_W]
//  id_imm_i       in   DATA_W            sign-extended immediate
//  id_ctrl_i      in   4                 {mem_read, mem_to_reg, mem_write, reg_write}
//  id_wr_reg_i    in   REG_ADDR_W        destination register
//  id_alu_ctrl_i  in   ALU_CTRL_W        ALU operation
//  ex_valid_o     out  1                 EX slot valid
//  ex_instr_o / ex_ops_o / ex_imm_o / ex_ctrl_o / ex_wr_reg_o / ex_alu_ctrl_o  out  (same widths)  registered copies
//  cnt_clr_i      in   1                 synchronous clear of all perf counters
//  stall_cnt_o / flush_cnt_o / bubble_cnt_o  out  CNT_W  perf counters
// BEHAVIOUR
//  Reset (rst_n=0, async): every output 0; ex_instr_o = NOP_INSTR (32'h0 for DATA_W=32). Counters 0.
//  Latency: 1 cycle ID->EX when loading. Per posedge, priority flush > stall > load:
//   flush_i=1: ex_valid_o<=0, ex_ctrl_o<=0, ex_wr_reg_o<=0, ex_alu_ctrl_o<=0, ex_instr_o<=NOP_INSTR, ops/imm<=0. Overrides stall.
//   stall_i=1 (no flush): all EX outputs hold previous value, ID inputs ignored.
//   else id_valid_i=1: all fields loaded from ID inputs, ex_valid_o<=1.
//   else id_valid_i=0: bubble loaded (same values as flush).
//  Invariant: ex_valid_o=0 implies ex_ctrl_o==0 and ex_wr_reg_o==0 (no spurious mem/wb side effects).
//  Stall for any number of cycles must not corrupt held data; release resumes load next edge.
//  Reset deassertion mid-stall: first edge after release obeys normal priority; no residual state.
//  No handshake back to ID; upstream hazard logic owns stall_i/flush_i generation.
// CONFIGURATION
//  IDEX_PERF_CNT_EN defined: per edge (cnt_clr_i has top priority -> all 0):
//   stall_cnt_o +1 when stall_i & ~flush_i; flush_cnt_o +1 when flush_i;
//   bubble_cnt_o +1 when ~stall_i & ~flush_i & ~id_valid_i. All saturate at 2^CNT_W-1 (no wrap).
//  Not defined: counter ports present, tied to 0, no counter flops; cnt_clr_i ignored.
// STRUCTURE
//  Package idex_pkg: ctrl_t packed struct {mem_read, mem_to_reg, mem_write, reg_write};
//   NOP_INSTR constant; CTRL_BUBBLE constant (all zero).
//  Sub-module idex_perf_cnt (one saturating counter, inc/clr, CNT_W): instantiated 3x under the macro.
//  Datapath: single next-state mux (flush/stall/load/bubble) feeding one register bank.
// TESTING
//  1 Reset: assert rst_n=0 mid-cycle with ex_valid_o=1 -> all outputs 0 immediately, counters 0.
//  2 Load: id_valid_i=1, instr=32'h8C220004, op0=5, op1=7, ctrl=4'b1101 -> next edge EX matches, ex_valid_o=1.
//  3 Stall: load A, stall_i=1 for 3 edges while ID shows B -> EX holds A; release -> B after 1 edge.
//  4 Flush+stall same cycle: ex holds valid store (ctrl=0010) -> ex_valid_o=0, ex_ctrl_o=0, ex_instr_o=0.
//  5 Bubble: id_valid_i=0, ctrl inputs=4'b1111 -> ex_ctrl_o=0, ex_wr_reg_o=0, ex_valid_o=0.
//  6 IDEX_PERF_CNT_EN, CNT_W=4: 20 stall cycles -> stall_cnt_o=15 (saturated); cnt_clr_i=1 -> 0.

Source files
------------

// File: rtl/idex_pkg.sv
// rtl/idex_pkg.sv - shared types and constants for the ID->EX pipeline stage
package idex_pkg;

    typedef struct packed {
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic reg_write;
    } ctrl_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0;
    localparam ctrl_t       CTRL_BUBBLE = '0;

endpackage

// File: rtl/idex_if.sv
// rtl/idex_if.sv - ID-side inputs, EX-side outputs and perf counter bus of the ID->EX stage
interface idex_if
    import idex_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_OPS    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 16
) ();

    logic                      stall_i;
    logic                      flush_i;
    logic                      id_valid_i;
    logic [DATA_W-1:0]         id_instr_i;
    logic [NUM_OPS*DATA_W-1:0] id_ops_i;
    logic [DATA_W-1:0]         id_imm_i;
    ctrl_t                     id_ctrl_i;
    logic [REG_ADDR_W-1:0]     id_wr_reg_i;
    logic [ALU_CTRL_W-1:0]     id_alu_ctrl_i;

    logic                      ex_valid_o;
    logic [DATA_W-1:0]         ex_instr_o;
    logic [NUM_OPS*DATA_W-1:0] ex_ops_o;
    logic [DATA_W-1:0]         ex_imm_o;
    ctrl_t                     ex_ctrl_o;
    logic [REG_ADDR_W-1:0]     ex_wr_reg_o;
    logic [ALU_CTRL_W-1:0]     ex_alu_ctrl_o;

    logic                      cnt_clr_i;
    logic [CNT_W-1:0]          stall_cnt_o;
    logic [CNT_W-1:0]          flush_cnt_o;
    logic [CNT_W-1:0]          bubble_cnt_o;

    modport slave (
        input  stall_i, flush_i, id_valid_i, id_instr_i, id_ops_i, id_imm_i,
               id_ctrl_i, id_wr_reg_i, id_alu_ctrl_i, cnt_clr_i,
        output ex_valid_o, ex_instr_o, ex_ops_o, ex_imm_o, ex_ctrl_o,
               ex_wr_reg_o, ex_alu_ctrl_o, stall_cnt_o, flush_cnt_o, bubble_cnt_o
    );

    modport master (
        output stall_i, flush_i, id_valid_i, id_instr_i, id_ops_i, id_imm_i,
               id_ctrl_i, id_wr_reg_i, id_alu_ctrl_i, cnt_clr_i,
        input  ex_valid_o, ex_instr_o, ex_ops_o, ex_imm_o, ex_ctrl_o,
               ex_wr_reg_o, ex_alu_ctrl_o, stall_cnt_o, flush_cnt_o, bubble_cnt_o
    );

endinterface

// File: rtl/idex_perf_cnt.sv
// rtl/idex_perf_cnt.sv - saturating event counter with synchronous clear
module idex_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/idex_pipe_stage.sv
// rtl/idex_pipe_stage.sv - ID->EX stage register with stall hold, flush/bubble insert
// Optional perf counters enabled by defining IDEX_PERF_CNT_EN.
module idex_pipe_stage
    import idex_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_OPS    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 16
) (
    input logic   clk,
    input logic   rst_n,
    idex_if.slave bus
);

    localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_INSTR);

    logic                      exValid,   nextValid;
    logic [DATA_W-1:0]         exInstr,   nextInstr;
    logic [NUM_OPS*DATA_W-1:0] exOps,     nextOps;
    logic [DATA_W-1:0]         exImm,     nextImm;
    ctrl_t                     exCtrl,    nextCtrl;
    logic [REG_ADDR_W-1:0]     exWrReg,   nextWrReg;
    logic [ALU_CTRL_W-1:0]     exAluCtrl, nextAluCtrl;

    logic insertBubble;
    assign insertBubble = bus.flush_i || (!bus.stall_i && !bus.id_valid_i);

    // Bubble forces ctrl/wr_reg to zero so an invalid slot can never write memory or registers.
    always_comb begin
        nextValid   = exValid;
        nextInstr   = exInstr;
        nextOps     = exOps;
        nextImm     = exImm;
        nextCtrl    = exCtrl;
        nextWrReg   = exWrReg;
        nextAluCtrl = exAluCtrl;
        if (insertBubble) begin
            nextValid   = 1'b0;
            nextInstr   = NOP;
            nextOps     = '0;
            nextImm     = '0;
            nextCtrl    = CTRL_BUBBLE;
            nextWrReg   = '0;
            nextAluCtrl = '0;
        end else if (!bus.stall_i) begin
            nextValid   = 1'b1;
            nextInstr   = bus.id_instr_i;
            nextOps     = bus.id_ops_i;
            nextImm     = bus.id_imm_i;
            nextCtrl    = bus.id_ctrl_i;
            nextWrReg   = bus.id_wr_reg_i;
            nextAluCtrl = bus.id_alu_ctrl_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exValid   <= 1'b0;
            exInstr   <= NOP;
            exOps     <= '0;
            exImm     <= '0;
            exCtrl    <= CTRL_BUBBLE;
            exWrReg   <= '0;
            exAluCtrl <= '0;
        end else begin
            exValid   <= nextValid;
            exInstr   <= nextInstr;
            exOps     <= nextOps;
            exImm     <= nextImm;
            exCtrl    <= nextCtrl;
            exWrReg   <= nextWrReg;
            exAluCtrl <= nextAluCtrl;
        end
    end

    assign bus.ex_valid_o    = exValid;
    assign bus.ex_instr_o    = exInstr;
    assign bus.ex_ops_o      = exOps;
    assign bus.ex_imm_o      = exImm;
    assign bus.ex_ctrl_o     = exCtrl;
    assign bus.ex_wr_reg_o   = exWrReg;
    assign bus.ex_alu_ctrl_o = exAluCtrl;

`ifdef IDEX_PERF_CNT_EN
    idex_perf_cnt #(.CNT_W(CNT_W)) uStallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.cnt_clr_i),
        .inc   (bus.stall_i && !bus.flush_i),
        .cnt   (bus.stall_cnt_o)
    );

    idex_perf_cnt #(.CNT_W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.cnt_clr_i),
        .inc   (bus.flush_i),
        .cnt   (bus.flush_cnt_o)
    );

    idex_perf_cnt #(.CNT_W(CNT_W)) uBubbleCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.cnt_clr_i),
        .inc   (!bus.stall_i && !bus.flush_i && !bus.id_valid_i),
        .cnt   (bus.bubble_cnt_o)
    );
`else
    logic unusedCntClr;
    assign unusedCntClr     = bus.cnt_clr_i;
    assign bus.stall_cnt_o  = '0;
    assign bus.flush_cnt_o  = '0;
    assign bus.bubble_cnt_o = '0;
`endif

endmodule
